gate_drv: RTL and testbench
===========================

Name: gate_drv

Overview:
- Downstream of the phase-advance stage.
- Consumes its phase-advanced feedback sgn_pre and drives the two complementary H-bridge gate pairs of the DRSSTC, with programmable dead time.
- Bursts are gated by the interrupter. Every start and stop is aligned to a feedback zero-crossing (an sgn_pre edge).
- Over-current fault: the bridge is shut down at the next zero-crossing and the fault is latched.

Parameters:
- DT_PARAMETER, 255, max dead time in clk cycles; dt width = $clog2(DT_PARAMETER+1).
- CYC_PARAMETER, 1023, max half-cycles per burst; max_cyc and cycle-counter width = $clog2(CYC_PARAMETER+1).
- WDOG_PARAMETER, 4095, feedback-loss timeout in clk cycles (used only with WDOG_EN).

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- sgn_pre  input  1  phase-advanced feedback, registered in the clk domain, no sync required.
- intr  input  1  interrupter enable; level, synchronous to clk.
- ocd  input  1  over-current detect; synchronous, active-high.
- dt  input  $clog2(DT_PARAMETER+1)  dead time in cycles; sampled at each edge.
- max_cyc  input  $clog2(CYC_PARAMETER+1)  half-cycle limit per burst; 0 = unlimited.
- out_a  output  1  gate pair A (conducts while sgn_pre=1).
- out_b  output  1  gate pair B (conducts while sgn_pre=0).
- busy  output  1  burst in progress (any state other than IDLE).
- fault  output  1  latched over-current (or watchdog) shutdown.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sgn_d = 0.
- Edge detect:
  - sgn_d is registered from sgn_pre; edge = sgn_pre ^ sgn_d.
  - The first cycle after reset never produces a spurious edge: sgn_d loads sgn_pre during IDLE.
- Invariant: out_a & out_b is never 1, including across reset and every state transition.
- Outputs are registered.
- IDLE:
  - out_a = out_b = 0; sgn_d tracks sgn_pre.
  - If intr=1 and fault=0: go to ARMED; cycle counter cleared.
  - If intr=0: fault clears.
- ARMED:
  - If intr drops: back to IDLE next cycle.
  - On an edge: go to DEAD; the polarity register loads sgn_pre.
- DEAD:
  - Both outputs 0 for exactly max(dt,1) cycles; minimum dead time is 1.
  - An edge during DEAD restarts the dead count and reloads polarity.
  - On expiry: go to DRIVE; out_a = pol, out_b = ~pol from the next cycle.
- DRIVE, on an edge:
  - Outputs go to 0 on the next cycle.
  - Cycle counter increments.
  - Go to IDLE if any of these hold: intr=0; stop_req=1; max_cyc != 0 and the counter reaches max_cyc.
  - Otherwise go to DEAD with the new polarity.
- Edge to gate-off latency: 1 clk.
- Edge to opposite gate-on latency: 1 + max(dt,1) clk.
- OCD:
  - ocd=1 in DEAD or DRIVE sets stop_req; fault is set in the same cycle.
  - The burst terminates at the next edge; there is no mid-half-cycle hard switching.
  - ocd in ARMED: fault set, return to IDLE immediately.
  - fault blocks re-arming until intr=0 is seen in IDLE.
- Simultaneous events:
  - An edge and intr falling in the same cycle: treated as a stop at that edge.
  - ocd and an edge in the same cycle: stop at that edge, fault set.
- dt changes mid-burst take effect at the next edge only.
- Cycle counter saturates at CYC_PARAMETER; no wrap.
- Asynchronous reset mid-DRIVE: both outputs forced to 0 immediately; fault cleared.

Optional Feature:
- Macro: GATE_DRV_WDOG_EN.
- Defined:
  - A watchdog counter runs in DEAD and DRIVE and is cleared on every edge.
  - Reaching WDOG_PARAMETER (feedback lost) forces both outputs to 0 next cycle, state to IDLE, and fault=1.
- Undefined: no watchdog logic; a stalled sgn_pre holds the current gate state indefinitely.

Test Plan:
- Basic burst:
  - Stimulus: dt=3, max_cyc=0, intr=1, sgn_pre toggling every 20 clk.
  - Response: first edge gives 4 clk with both low, then pair matching sgn_pre. Each edge gives outputs low next clk and the opposite pair on 4 clk after the edge. out_a&out_b never 1.
- Zero-aligned stop:
  - Stimulus: intr drops 7 clk after an edge.
  - Response: gates unchanged until the next edge; off 1 clk after it; busy=0; no further drive.
- Cycle limit:
  - Stimulus: max_cyc=5.
  - Response: exactly 5 driven half-cycles, then IDLE despite intr=1; re-arm needs no intr toggle.
- OCD:
  - Stimulus: ocd pulse for 1 clk mid-DRIVE.
  - Response: fault=1 immediately; outputs off at the next edge +1; intr held high does not re-arm. After intr=0 then 1, fault=0 and the burst restarts.
- Boundaries:
  - Stimulus: dt=0 → 1-cycle dead time.
  - Stimulus: sgn_pre glitch (edge back) during DEAD → dead count restarts, drive polarity follows final level.
  - Stimulus: rst_n low during DRIVE → outputs 0 asynchronously.
- Watchdog (GATE_DRV_WDOG_EN, WDOG_PARAMETER=100):
  - Stimulus: sgn_pre frozen mid-DRIVE.
  - Response: outputs 0 at clk 101 after the last edge; fault=1; busy=0.

Source files
------------

// File: rtl/gate_drv.sv
// gate_drv: H-bridge gate driver for a DRSSTC.
// It takes the phase-advanced feedback sgn_pre and drives two complementary
// gate pairs with programmable dead time. Bursts are gated by intr, and every
// start and stop falls on a feedback zero-crossing. An over-current stops the
// bridge at the next crossing and latches fault.
// Optional feature macro: GATE_DRV_WDOG_EN adds a feedback-loss watchdog.
module gate_drv #(
  parameter int DT_PARAMETER   = 255,
  parameter int CYC_PARAMETER  = 1023,
  parameter int WDOG_PARAMETER = 4095
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sgn_pre,
  input  logic                               intr,
  input  logic                               ocd,
  input  logic [$clog2(DT_PARAMETER+1)-1:0]  dt,
  input  logic [$clog2(CYC_PARAMETER+1)-1:0] max_cyc,
  output logic                               out_a,
  output logic                               out_b,
  output logic                               busy,
  output logic                               fault
);

  localparam int DT_W  = $clog2(DT_PARAMETER + 1);
  localparam int CYC_W = $clog2(CYC_PARAMETER + 1);

  localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ZERO = CYC_W'(0);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_MAX  = CYC_W'(CYC_PARAMETER);

  // Reject parameter values that would leave a counter without a usable range.
  if (DT_PARAMETER < 1 || CYC_PARAMETER < 1 || WDOG_PARAMETER < 2) begin : g_param_check
    $error("gate_drv: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             sgn_d_r;
  logic             pol_r, pol_s;
  logic [DT_W-1:0]  dead_cnt_r, dead_cnt_s;
  logic [CYC_W-1:0] cyc_cnt_r, cyc_cnt_s;
  logic             stop_req_r, stop_req_s;
  logic             fault_r, fault_s;
  logic             out_a_r, out_a_s;
  logic             out_b_r, out_b_s;
  logic             busy_r, busy_s;

  logic             edge_s;
  logic [DT_W-1:0]  dt_eff_s;
  logic [CYC_W-1:0] cyc_inc_s;
  logic             limit_hit_s;

  assign edge_s      = sgn_pre ^ sgn_d_r;
  // A programmed dead time of zero still leaves one cycle with both pairs off.
  assign dt_eff_s    = (dt == {DT_W{1'b0}}) ? DT_ONE : dt;
  assign cyc_inc_s   = (cyc_cnt_r == CYC_MAX) ? cyc_cnt_r : (cyc_cnt_r + CYC_ONE);
  assign limit_hit_s = (max_cyc != CYC_ZERO) && (cyc_inc_s >= max_cyc);

`ifdef GATE_DRV_WDOG_EN
  localparam int WD_W = $clog2(WDOG_PARAMETER + 1);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_PARAMETER - 1);

  logic [WD_W-1:0] wdog_cnt_r, wdog_cnt_s;
  logic            wdog_trip_s;

  // Feedback-loss timer: counts cycles without an edge while the bridge is active.
  always_comb begin
    wdog_cnt_s  = WD_ZERO;
    wdog_trip_s = 1'b0;
    if ((state_r == ST_DEAD || state_r == ST_DRIVE) && !edge_s) begin
      if (wdog_cnt_r == WD_LAST) begin
        wdog_trip_s = 1'b1;
      end else begin
        wdog_cnt_s = wdog_cnt_r + WD_ONE;
      end
    end else begin
      wdog_cnt_s = WD_ZERO;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= WD_ZERO;
    end else begin
      wdog_cnt_r <= wdog_cnt_s;
    end
  end
`endif

  // Next-state and next-output logic; gate pairs only change on edge-aligned transitions.
  always_comb begin
    state_s    = state_r;
    pol_s      = pol_r;
    dead_cnt_s = dead_cnt_r;
    cyc_cnt_s  = cyc_cnt_r;
    stop_req_s = stop_req_r;
    fault_s    = fault_r;
    out_a_s    = 1'b0;
    out_b_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        stop_req_s = 1'b0;
        if (!intr) begin
          fault_s = 1'b0;
        end else if (!fault_r) begin
          state_s   = ST_ARMED;
          cyc_cnt_s = CYC_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ARMED: begin
        if (ocd) begin
          fault_s = 1'b1;
          state_s = ST_IDLE;
        end else if (!intr) begin
          state_s = ST_IDLE;
        end else if (edge_s) begin
          state_s    = ST_DEAD;
          pol_s      = sgn_pre;
          dead_cnt_s = dt_eff_s;
        end else begin
          state_s = ST_ARMED;
        end
      end

      ST_DEAD: begin
        if (ocd) begin
          stop_req_s = 1'b1;
          fault_s    = 1'b1;
        end else begin
          stop_req_s = stop_req_r;
        end
`ifdef GATE_DRV_WDOG_EN
        if (wdog_trip_s) begin
          state_s = ST_IDLE;
          fault_s = 1'b1;
        end else
`endif
        if (edge_s && (stop_req_r || ocd || !intr)) begin
          state_s = ST_IDLE;
        end else if (edge_s) begin
          // A glitch back during dead time restarts the wait on the final level.
          pol_s      = sgn_pre;
          dead_cnt_s = dt_eff_s;
        end else if (dead_cnt_r <= DT_ONE) begin
          state_s = ST_DRIVE;
          out_a_s = pol_r;
          out_b_s = ~pol_r;
        end else begin
          dead_cnt_s = dead_cnt_r - DT_ONE;
        end
      end

      ST_DRIVE: begin
        if (ocd) begin
          stop_req_s = 1'b1;
          fault_s    = 1'b1;
        end else begin
          stop_req_s = stop_req_r;
        end
`ifdef GATE_DRV_WDOG_EN
        if (wdog_trip_s) begin
          state_s = ST_IDLE;
          fault_s = 1'b1;
        end else
`endif
        if (edge_s) begin
          cyc_cnt_s = cyc_inc_s;
          if (!intr || stop_req_r || ocd || limit_hit_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s    = ST_DEAD;
            pol_s      = sgn_pre;
            dead_cnt_s = dt_eff_s;
          end
        end else begin
          // Hold the conducting pair until the next zero-crossing.
          out_a_s = out_a_r;
          out_b_s = out_b_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs; reset forces both gate pairs off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      sgn_d_r    <= 1'b0;
      pol_r      <= 1'b0;
      dead_cnt_r <= {DT_W{1'b0}};
      cyc_cnt_r  <= CYC_ZERO;
      stop_req_r <= 1'b0;
      fault_r    <= 1'b0;
      out_a_r    <= 1'b0;
      out_b_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sgn_d_r    <= sgn_pre;
      pol_r      <= pol_s;
      dead_cnt_r <= dead_cnt_s;
      cyc_cnt_r  <= cyc_cnt_s;
      stop_req_r <= stop_req_s;
      fault_r    <= fault_s;
      out_a_r    <= out_a_s;
      out_b_r    <= out_b_s;
      busy_r     <= busy_s;
    end
  end

  assign out_a = out_a_r;
  assign out_b = out_b_r;
  assign busy  = busy_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_gate_drv.sv
// tb_gate_drv: directed self-checking bench for gate_drv.
// Inputs change 1 time unit after a rising clock edge; outputs are sampled at
// the same point, so a registered response to an input change made after
// edge k is visible after edge k+1.
module tb_gate_drv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sgn_pre;
  logic       intr;
  logic       ocd;
  logic [7:0] dt;
  logic [9:0] max_cyc;
  logic       out_a;
  logic       out_b;
  logic       busy;
  logic       fault;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_pair;

  always #5 clk = ~clk;

  gate_drv #(
    .DT_PARAMETER  (255),
    .CYC_PARAMETER (1023),
    .WDOG_PARAMETER(100)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sgn_pre(sgn_pre),
    .intr   (intr),
    .ocd    (ocd),
    .dt     (dt),
    .max_cyc(max_cyc),
    .out_a  (out_a),
    .out_b  (out_b),
    .busy   (busy),
    .fault  (fault)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; after each one the two gate pairs must not overlap.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("no_overlap", {3'b000, out_a & out_b}, 4'h0);
    end
  endtask

  // Toggle sgn_pre and check gate-off after 1 clk, dead time of dte clks,
  // then the pair matching the new level (or nothing when the burst stops).
  task automatic edge_chk(input string tag, input int dte, input bit on, input int hold);
    logic [1:0] pair;
    sgn_pre = ~sgn_pre;
    step(1);
    check({tag, "_off"}, {2'b00, out_a, out_b}, 4'h0);
    check({tag, "_busy"}, {3'b000, busy}, {3'b000, on});
    if (dte > 1) step(dte - 1);
    check({tag, "_dead"}, {2'b00, out_a, out_b}, 4'h0);
    step(1);
    pair = on ? {sgn_pre, ~sgn_pre} : 2'b00;
    check({tag, "_on"}, {2'b00, out_a, out_b}, {2'b00, pair});
    if (hold > dte + 1) step(hold - dte - 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    sgn_pre = 1'b0;
    intr    = 1'b0;
    ocd     = 1'b0;
    dt      = 8'd3;
    max_cyc = 10'd0;

    // Reset state
    step(3);
    check("rst_outs", {2'b00, out_a, out_b}, 4'h0);
    check("rst_busy", {3'b000, busy}, 4'h0);
    check("rst_fault", {3'b000, fault}, 4'h0);
    rst_n = 1'b1;
    step(2);
    check("idle_outs", {2'b00, out_a, out_b}, 4'h0);
    check("idle_busy", {3'b000, busy}, 4'h0);

    // Basic burst, dt=3, half-period 20 clk
    intr = 1'b1;
    step(1);
    check("armed_busy", {3'b000, busy}, 4'h1);
    check("armed_outs", {2'b00, out_a, out_b}, 4'h0);
    step(5);
    edge_chk("basic1", 3, 1'b1, 20);
    edge_chk("basic2", 3, 1'b1, 20);
    edge_chk("basic3", 3, 1'b1, 20);
    edge_chk("basic4", 3, 1'b1, 20);

    // dt=0 gives one dead cycle; a mid-burst change applies from the next edge
    dt = 8'd0;
    edge_chk("dt0", 1, 1'b1, 20);
    dt = 8'd3;
    edge_chk("dt3", 3, 1'b1, 20);

    // Zero-aligned stop: intr drops 7 clk after an edge
    edge_chk("stop_pre", 3, 1'b1, 7);
    intr     = 1'b0;
    exp_pair = {sgn_pre, ~sgn_pre};
    step(5);
    check("stop_hold", {2'b00, out_a, out_b}, {2'b00, exp_pair});
    check("stop_hold_busy", {3'b000, busy}, 4'h1);
    sgn_pre = ~sgn_pre;
    step(1);
    check("stop_off", {2'b00, out_a, out_b}, 4'h0);
    check("stop_busy", {3'b000, busy}, 4'h0);
    step(6);
    sgn_pre = ~sgn_pre;
    step(6);
    check("stop_nodrive", {2'b00, out_a, out_b}, 4'h0);
    check("stop_idle", {3'b000, busy}, 4'h0);

    // Cycle limit: five driven half-cycles, then automatic re-arm
    max_cyc = 10'd5;
    intr    = 1'b1;
    step(2);
    edge_chk("cyc_start", 3, 1'b1, 20);
    for (int i = 0; i < 4; i++) edge_chk("cyc_mid", 3, 1'b1, 20);
    edge_chk("cyc_stop", 3, 1'b0, 20);
    edge_chk("cyc_rearm", 3, 1'b1, 20);
    max_cyc = 10'd0;

    // Over-current mid-DRIVE
    edge_chk("ocd_pre", 3, 1'b1, 10);
    exp_pair = {sgn_pre, ~sgn_pre};
    ocd = 1'b1;
    step(1);
    ocd = 1'b0;
    check("ocd_fault", {3'b000, fault}, 4'h1);
    check("ocd_nohard", {2'b00, out_a, out_b}, {2'b00, exp_pair});
    check("ocd_busy", {3'b000, busy}, 4'h1);
    step(4);
    check("ocd_hold", {2'b00, out_a, out_b}, {2'b00, exp_pair});
    sgn_pre = ~sgn_pre;
    step(1);
    check("ocd_off", {2'b00, out_a, out_b}, 4'h0);
    check("ocd_stop_busy", {3'b000, busy}, 4'h0);
    check("ocd_latched", {3'b000, fault}, 4'h1);
    step(10);
    check("ocd_no_rearm", {3'b000, busy}, 4'h0);
    sgn_pre = ~sgn_pre;
    step(3);
    check("ocd_no_drive", {2'b00, out_a, out_b}, 4'h0);
    check("ocd_still_fault", {3'b000, fault}, 4'h1);
    intr = 1'b0;
    step(1);
    check("ocd_clear", {3'b000, fault}, 4'h0);
    intr = 1'b1;
    step(1);
    check("ocd_rearm", {3'b000, busy}, 4'h1);
    step(3);
    edge_chk("ocd_restart", 3, 1'b1, 20);

    // Glitch back during DEAD restarts the dead count on the final level
    sgn_pre = ~sgn_pre;
    step(1);
    check("glitch_off", {2'b00, out_a, out_b}, 4'h0);
    step(1);
    edge_chk("glitch", 3, 1'b1, 20);

    // Asynchronous reset mid-DRIVE, with fault latched beforehand
    ocd = 1'b1;
    step(1);
    ocd = 1'b0;
    check("arst_pre_fault", {3'b000, fault}, 4'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {2'b00, out_a, out_b}, 4'h0);
    check("arst_fault", {3'b000, fault}, 4'h0);
    check("arst_busy", {3'b000, busy}, 4'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("arst_rearm", {3'b000, busy}, 4'h1);
    step(2);

`ifdef GATE_DRV_WDOG_EN
    // Feedback frozen mid-DRIVE: gates off 101 clk after the last edge
    edge_chk("wd", 3, 1'b1, 4);
    exp_pair = {sgn_pre, ~sgn_pre};
    step(96);
    check("wd_hold", {2'b00, out_a, out_b}, {2'b00, exp_pair});
    step(1);
    check("wd_off", {2'b00, out_a, out_b}, 4'h0);
    check("wd_fault", {3'b000, fault}, 4'h1);
    check("wd_busy", {3'b000, busy}, 4'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
